pif_si_dma: RTL

- Serial-interface DMA sequencer that moves one 64-byte PIF RAM image between the 32-bit word port of the PIF RAM and the system memory bus.
- Sits directly between the memory bus and the PIF RAM word port (4-bit word address, write enable, 32-bit write data, registered 32-bit read data with 1-cycle latency).
- Two directions: PIF->memory (SI read, 64B) and memory->PIF (SI write, 64B); one transfer at a time, done pulse on completion.

---
 rtl/pif_si_pkg.sv | 19 +
 rtl/pif_si_watchdog.sv | 36 +++
 rtl/pif_si_dma.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pif_si_pkg.sv
// Shared types and constants for the serial-interface DMA sequencer.
// Holds the FSM state encoding and the transfer-direction codes.
package pif_si_pkg;

   localparam int   PIF_WORDS   = 16;
   localparam logic DIR_MEM2PIF = 1'b0;
   localparam logic DIR_PIF2MEM = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PIF_ADDR,
      S_PIF_CAP,
      S_MEM_WR,
      S_MEM_RD,
      S_PIF_WR,
      S_DONE
   } si_state_e;

endpackage

// File: rtl/pif_si_watchdog.sv
// Bus-wait watchdog: counts cycles without mem_ack while a beat is pending.
// expired_o fires on the last allowed wait cycle so the FSM can abort immediately.
module pif_si_watchdog #(
   parameter int TIMEOUT = 1023
) (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic clear_i,
   input  logic count_i,
   output logic expired_o
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] tcnt_q, tcnt_d;

   always_comb begin
      tcnt_d = tcnt_q;
      if (clear_i) begin
         tcnt_d = '0;
      end else if (count_i) begin
         tcnt_d = tcnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         tcnt_q <= '0;
      end else begin
         tcnt_q <= tcnt_d;
      end
   end

   assign expired_o = count_i && (tcnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/pif_si_dma.sv
// Serial-interface DMA sequencer moving one 64-byte PIF RAM image between
// the PIF RAM word port and the memory bus, in either direction.
module pif_si_dma
   import pif_si_pkg::*;
#(
   parameter int ADDR_W  = 24,
   parameter int WORDS   = PIF_WORDS,
   parameter int TIMEOUT = 1023
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   input  logic              start_i,
   input  logic              dir_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [31:0]       mem_rdata_i,
   output logic [3:0]        pif_addr_o,
   output logic              pif_wren_o,
   output logic [31:0]       pif_wdata_o,
   input  logic [31:0]       pif_rdata_i
);

   si_state_e         state_q, state_d;
   logic [3:0]        idx_q, idx_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [31:0]       dbuf_q, dbuf_d;
   logic              error_q, error_d;
   logic              in_mem, expired, last_word;

   assign in_mem    = (state_q == S_MEM_WR) || (state_q == S_MEM_RD);
   assign last_word = (idx_q == 4'(WORDS - 1));

   // The watchdog restarts whenever we are outside a bus beat, i.e. on every entry.
   pif_si_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .clear_i   (!in_mem),
      .count_i   (in_mem && !mem_ack_i),
      .expired_o (expired)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      base_d  = base_q;
      dbuf_d  = dbuf_q;
      error_d = error_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               base_d  = base_addr_i & ~ADDR_W'(3);
               idx_d   = '0;
               error_d = 1'b0;
               state_d = (dir_i == DIR_PIF2MEM) ? S_PIF_ADDR : S_MEM_RD;
            end
         end
         S_PIF_ADDR: state_d = S_PIF_CAP;
         S_PIF_CAP: begin
            dbuf_d  = pif_rdata_i;
            state_d = S_MEM_WR;
         end
         S_MEM_WR: begin
            if (mem_ack_i) begin
               if (last_word) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = S_PIF_ADDR;
               end
            end else if (expired) begin
               error_d = 1'b1;
               state_d = S_DONE;
            end
         end
         S_MEM_RD: begin
            if (mem_ack_i) begin
               dbuf_d  = mem_rdata_i;
               state_d = S_PIF_WR;
            end else if (expired) begin
               error_d = 1'b1;
               state_d = S_DONE;
            end
         end
         S_PIF_WR: begin
            if (last_word) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 4'd1;
               state_d = S_MEM_RD;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         base_q  <= '0;
         dbuf_q  <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         base_q  <= base_d;
         dbuf_q  <= dbuf_d;
         error_q <= error_d;
      end
   end

   // Moore outputs decoded purely from registered state; the adder wraps at the top of memory.
   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = (state_q == S_DONE);
   assign error_o     = error_q;
   assign mem_req_o   = in_mem;
   assign mem_we_o    = (state_q == S_MEM_WR);
   assign mem_addr_o  = base_q + ADDR_W'({idx_q, 2'b00});
   assign mem_wdata_o = dbuf_q;
   assign pif_addr_o  = idx_q;
   assign pif_wren_o  = (state_q == S_PIF_WR);
   assign pif_wdata_o = dbuf_q;

endmodule
